cpu_bus_interface: RTL

//  Per-CPU requester stage that sits directly upstream of system_bus (one instance per CPU port).

---
 rtl/cpu_bus_interface.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cpu_bus_interface.sv
// rtl/cpu_bus_interface.sv - per-CPU requester stage driving one system_bus port
module cpu_bus_interface #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_valid,
    output logic       cpu_ready,
    input  logic       cpu_rw,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       resp_err,
    output logic       req,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       rw_select,
    input  logic       enable,
    input  logic [7:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        XFER     = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             cpu_ready_q, cpu_ready_d;
    logic             req_q, req_d;
    logic [7:0]       bus_addr_q, bus_addr_d;
    logic [7:0]       bus_wdata_q, bus_wdata_d;
    logic             rw_select_q, rw_select_d;
    logic             resp_valid_q, resp_valid_d;
    logic [7:0]       resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state and next-output logic; every output is registered so the
    // values computed here appear on the ports one cycle later.
    always_comb begin
        state_d      = state_q;
        cpu_ready_d  = cpu_ready_q;
        req_d        = req_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        rw_select_d  = rw_select_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                cpu_ready_d = 1'b1;
                resp_err_d  = 1'b0;
                if (cpu_valid && cpu_ready_q) begin
                    rw_select_d = cpu_rw;
                    bus_addr_d  = cpu_addr;
                    bus_wdata_d = cpu_wdata;
                    req_d       = 1'b1;
                    cpu_ready_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (enable) begin
                    // The grant cycle is the first cycle of the data window,
                    // so a read captures the bus here as well.
                    state_d = XFER;
                    req_d   = 1'b0;
                    if (!rw_select_q) begin
                        resp_rdata_d = bus_rdata;
                    end
                end else if (cnt_q >= CNT_LAST) begin
                    state_d      = RESP;
                    req_d        = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end
            end
            XFER: begin
                if (enable) begin
                    if (!rw_select_q) begin
                        resp_rdata_d = bus_rdata;
                    end
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                end
            end
            RESP: begin
                cnt_d       = '0;
                resp_err_d  = 1'b0;
                cpu_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d     = IDLE;
                req_d       = 1'b0;
                cpu_ready_d = 1'b1;
                cnt_d       = '0;
            end
        endcase
    end

    // State and output registers; reset drops req at once and discards any
    // transaction in flight without producing a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cpu_ready_q  <= 1'b1;
            req_q        <= 1'b0;
            bus_addr_q   <= 8'h00;
            bus_wdata_q  <= 8'h00;
            rw_select_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 8'h00;
            resp_err_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            cpu_ready_q  <= cpu_ready_d;
            req_q        <= req_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            rw_select_q  <= rw_select_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign cpu_ready  = cpu_ready_q;
    assign req        = req_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign rw_select  = rw_select_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
